// File: rtl/osd_dem_uart_package.sv
// ---------------------------------------------------------------------------
// osd_dem_uart_package
// Shared definitions for the DEM-UART blocks (character FIFO, 16550 model).
//   - CHAR_W        : width of a UART character
//   - trig_sel_e    : 16550 FCR receive trigger level encoding
//   - trig_level()  : converts a trigger select code into an entry count
// ---------------------------------------------------------------------------
package osd_dem_uart_package;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_14 = 2'd3
    } trig_sel_e;

    localparam int TRIG_LEVEL_1  = 1;
    localparam int TRIG_LEVEL_4  = 4;
    localparam int TRIG_LEVEL_8  = 8;
    localparam int TRIG_LEVEL_14 = 14;

    // Number of buffered entries at which the trigger condition is met.
    function automatic int trig_level(input logic [1:0] sel);
        int level;
        level = TRIG_LEVEL_14;
        case (trig_sel_e'(sel))
            TRIG_1:  level = TRIG_LEVEL_1;
            TRIG_4:  level = TRIG_LEVEL_4;
            TRIG_8:  level = TRIG_LEVEL_8;
            TRIG_14: level = TRIG_LEVEL_14;
            default: level = TRIG_LEVEL_14;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/osd_dem_uart_fifo_ram.sv
// ---------------------------------------------------------------------------
// osd_dem_uart_fifo_ram
// DEPTH x CHAR_W character storage: one write port, one registered read port.
// The array carries no reset so it maps onto block/distributed RAM.
// A read and a write to the same address in one cycle return the old data;
// the FIFO top forwards around that case itself.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address (sampled every cycle)
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module osd_dem_uart_fifo_ram
    import osd_dem_uart_package::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/osd_dem_uart_char_fifo.sv
// ---------------------------------------------------------------------------
// osd_dem_uart_char_fifo
// Character FIFO between the DEM-UART debug char streams and the 16550
// register model. Provides 16550-style occupancy and trigger status, a
// synchronous flush and a discard (drop) mode for a detached debug host.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   write-side character valid
//   in_char    in   write-side character
//   in_ready   out  write-side ready (registered)
//   out_valid  out  read-side character valid (registered)
//   out_char   out  read-side character (registered, holds when idle)
//   out_ready  in   read-side ready
//   flush      in   synchronous clear, wins over push and pop
//   drop       in   discard mode: accept and throw away write-side chars
//   trig_sel   in   trigger level select: 0->1, 1->4, 2->8, 3->14
//   count      out  occupancy 0..DEPTH
//   trig       out  count >= selected trigger level
//   empty      out  count == 0
//   full       out  count == DEPTH
//
// Organisation: every buffered character lives in the RAM, including the
// head. out_char is a register copy of the head. The RAM read port is
// always aimed at the entry just behind the next head, so that on a pop
// the new head is already sitting in the RAM read register. An entry that
// is written in the same cycle as its address is read is captured in a
// small forwarding register instead.
// ---------------------------------------------------------------------------
module osd_dem_uart_char_fifo
    import osd_dem_uart_package::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              drop,
    input  logic [1:0]        trig_sel,
    output logic [AW:0]       count,
    output logic              trig,
    output logic              empty,
    output logic              full
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam int            NUM_TRIG = 4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]     wr_ptr_reg,   wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg,   rd_ptr_next;
    logic [AW:0]       count_reg,    count_next;
    logic              out_valid_reg;
    logic [CHAR_W-1:0] out_char_reg, out_char_next;
    logic              in_ready_reg;
    logic              trig_reg,     trig_next;
    logic              empty_reg;
    logic              full_reg;
    logic              fwd_valid_reg, fwd_valid_next;
    logic [CHAR_W-1:0] fwd_data_reg;

    logic              push;
    logic              pop;
    logic [AW-1:0]     ram_rd_addr;
    logic [CHAR_W-1:0] ram_rd_data;
    logic [CHAR_W-1:0] next_head;
    logic [NUM_TRIG-1:0] trig_hit;

    // ------------------------------------------------------------------
    // Handshakes. The full check on push also covers the single cycle
    // after drop is released while full, where in_ready still reads 1.
    // ------------------------------------------------------------------
    assign push = in_valid && in_ready_reg && !drop && !flush && !full_reg;
    assign pop  = out_valid_reg && out_ready && !flush;

    // ------------------------------------------------------------------
    // Pointer and occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Read address is the entry after the head-to-be, i.e. the
    // character that becomes head on the following pop.
    // ------------------------------------------------------------------
    assign ram_rd_addr = rd_ptr_next + PTR_ONE;

    osd_dem_uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_char),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // The RAM returns stale data when the entry was written in the very
    // cycle it was read; the forwarding register holds the fresh value.
    assign fwd_valid_next = push && (wr_ptr_reg == ram_rd_addr);
    assign next_head      = fwd_valid_reg ? fwd_data_reg : ram_rd_data;

    // ------------------------------------------------------------------
    // Output register: the head moves on a pop, or a char lands directly
    // in it when the FIFO would otherwise be empty after this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        out_char_next = out_char_reg;
        if (!flush) begin
            if (pop) begin
                if (count_reg > CNT_ONE) begin
                    out_char_next = next_head;
                end else if (push) begin
                    out_char_next = in_char;
                end
            end else if (push && (count_reg == '0)) begin
                out_char_next = in_char;
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger: one comparator per level, selected by trig_sel.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
            assign trig_hit[gi] = int'(count_next) >= trig_level(2'(gi));
        end
    endgenerate

    assign trig_next = trig_hit[trig_sel];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_char_reg  <= '0;
            in_ready_reg  <= 1'b1;
            trig_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            fwd_valid_reg <= 1'b0;
            fwd_data_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= (count_next != '0);
            out_char_reg  <= out_char_next;
            // Discard mode keeps the write side open regardless of fill.
            in_ready_reg  <= drop || (count_next != CNT_FULL);
            trig_reg      <= trig_next;
            empty_reg     <= (count_next == '0);
            full_reg      <= (count_next == CNT_FULL);
            fwd_valid_reg <= fwd_valid_next;
            fwd_data_reg  <= in_char;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_char  = out_char_reg;
    assign count     = count_reg;
    assign trig      = trig_reg;
    assign empty     = empty_reg;
    assign full      = full_reg;

endmodule

// File: tb/tb_osd_dem_uart_char_fifo.sv
// ---------------------------------------------------------------------------
// tb_osd_dem_uart_char_fifo
// Directed scenarios followed by randomized traffic. A driver applies inputs
// just after each rising edge; an independent monitor on the falling edge
// compares the DUT against a queue-based reference FIFO and pops the
// expected character whenever the DUT delivers one.
// ---------------------------------------------------------------------------
module tb_osd_dem_uart_char_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_char = 8'h00;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_char;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          drop = 1'b0;
    logic [1:0]    trig_sel = 2'd0;
    logic [AW:0]   count;
    logic          trig;
    logic          empty;
    logic          full;

    int n_vec = 0;
    int n_err = 0;

    osd_dem_uart_char_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_ready (out_ready),
        .flush     (flush),
        .drop      (drop),
        .trig_sel  (trig_sel),
        .count     (count),
        .trig      (trig),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain queue of buffered characters.
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    bit         m_in_ready = 1'b1;
    bit         m_trig     = 1'b0;
    logic [7:0] m_last     = 8'h00;

    function automatic int lvl(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit         do_push;
        bit         do_pop;
        logic [7:0] exp_c;
        if (rst) begin
            exp_q.delete();
            m_in_ready = 1'b1;
            m_trig     = 1'b0;
            m_last     = 8'h00;
        end else begin
            chk("in_ready",  int'(in_ready),  int'(m_in_ready));
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("out_char",  int'(out_char),  int'(m_last));
            chk("count",     int'(count),     exp_q.size());
            chk("empty",     int'(empty),     int'(exp_q.size() == 0));
            chk("full",      int'(full),      int'(exp_q.size() == DEPTH));
            chk("trig",      int'(trig),      int'(m_trig));

            do_push = in_valid && m_in_ready && !drop && !flush && (exp_q.size() < DEPTH);
            do_pop  = (exp_q.size() != 0) && out_ready && !flush;

            if (do_pop) begin
                exp_c = exp_q.pop_front();
                chk("pop_char", int'(out_char), int'(exp_c));
                $display("deliver char %02h (expected %02h) at %0t", out_char, exp_c, $time);
            end
            if (flush) begin
                exp_q.delete();
            end else if (do_push) begin
                exp_q.push_back(in_char);
            end
            m_in_ready = drop || (exp_q.size() != DEPTH);
            m_trig     = exp_q.size() >= lvl(trig_sel);
            if (exp_q.size() != 0) begin
                m_last = exp_q[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic step(input logic v, input logic [7:0] c, input logic r,
                        input logic f, input logic d, input logic [1:0] ts);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_char   = c;
        out_ready = r;
        flush     = f;
        drop      = d;
        trig_sel  = ts;
    endtask

    task automatic drain(input int n, input logic [1:0] ts);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, ts);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single char, latency and status
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        drain(2, 2'd0);

        // Fill to full, 17th held off until a pop
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0);
        drain(20, 2'd0);

        // Streaming at count=5, pointers wrap
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 40; i++) step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0, 2'd1);
        drain(8, 2'd1);

        // Trigger level 8, then 14
        for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b1, 8'h67, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
        drain(10, 2'd3);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 10; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);

        // Discard mode
        for (int i = 0; i < 20; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1, 2'd0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        drain(2, 2'd0);

        // Reset mid-burst
        for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 8'hD2, 1'b1, 1'b0, 1'b0, 2'd0);
        drain(3, 2'd0);

        // Randomized traffic with bursty fill/drain phases
        for (int i = 0; i < 2000; i++) begin
            int  bias_v;
            int  bias_r;
            bias_v = ((i / 100) % 2 == 0) ? 80 : 40;
            bias_r = ((i / 100) % 2 == 0) ? 30 : 75;
            step(1'($urandom_range(0, 99) < bias_v),
                 8'($urandom),
                 1'($urandom_range(0, 99) < bias_r),
                 1'($urandom_range(0, 199) < 2),
                 1'($urandom_range(0, 99) < 6),
                 2'($urandom_range(0, 3)));
        end
        drain(20, 2'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
